// File: rtl/easy_avalon_host.sv
// Avalon-MM host: turns a valid/ready command stream into single-beat reads/writes
// and returns one response per command (read data, write ack or timeout).
module easy_avalon_host #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_DATA, RESP} state_t;

    localparam logic [7:0] TO_LIM   = 8'(TIMEOUT);
    localparam logic [2:0] LAT_LOAD = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cs_q, cs_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic              rvld_q, rvld_d, rto_q, rto_d;
    logic [7:0]        wait_q, wait_d;
    logic [2:0]        lat_q, lat_d;

    assign cmd_ready      = (state_q == IDLE) && !reset;
    assign rsp_valid      = rvld_q;
    assign rsp_readdata   = rdata_q;
    assign rsp_timeout    = rto_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_read_n     = rd_n_q;
    assign avm_writedata  = wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        wr_n_d  = wr_n_q;
        rd_n_d  = rd_n_q;
        rvld_d  = rvld_q;
        rto_d   = rto_q;
        wait_d  = wait_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    cs_d    = 1'b1;
                    wr_n_d  = !cmd_write;
                    rd_n_d  = cmd_write;
                    wait_d  = 8'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (avm_waitrequest) begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 == TO_LIM) begin
                        cs_d    = 1'b0;
                        wr_n_d  = 1'b1;
                        rd_n_d  = 1'b1;
                        rto_d   = 1'b1;
                        rdata_d = '0;
                        rvld_d  = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    cs_d   = 1'b0;
                    wr_n_d = 1'b1;
                    rd_n_d = 1'b1;
                    if (!wr_n_q) begin
                        rdata_d = '0;
                        rvld_d  = 1'b1;
                        state_d = RESP;
                    end else if (READ_LATENCY == 0) begin
                        rdata_d = avm_readdata;
                        rvld_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        // lat_q==0 marks the cycle READ_LATENCY after completion
                        lat_d   = LAT_LOAD;
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (lat_q == 3'd0) begin
                    rdata_d = avm_readdata;
                    rvld_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvld_d  = 1'b0;
                    rto_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            rvld_q  <= 1'b0;
            rto_q   <= 1'b0;
            wait_q  <= 8'd0;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            rvld_q  <= rvld_d;
            rto_q   <= rto_d;
            wait_q  <= wait_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: tb/tb_easy_avalon_host.sv
// Bench for easy_avalon_host: PIO-like slave with programmable stalls (latency 0,
// TIMEOUT=4) plus a second instance with READ_LATENCY=2 and a one-shot data slave.
module tb_easy_avalon_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  cmd_address = 2'd0;
    logic [31:0] cmd_writedata = 32'h0;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_readdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n, avm_read_n, avm_waitrequest;
    logic [31:0] avm_writedata, avm_readdata;

    easy_avalon_host #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata),
        .rsp_timeout(rsp_timeout),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    // Latency-2 instance
    logic        l_cmd_valid = 1'b0, l_cmd_write = 1'b0, l_rsp_ready = 1'b1;
    logic [1:0]  l_cmd_address = 2'd0;
    logic [31:0] l_cmd_writedata = 32'h0;
    logic        l_cmd_ready, l_rsp_valid, l_rsp_timeout;
    logic [31:0] l_rsp_readdata;
    logic [1:0]  l_avm_address;
    logic        l_avm_chipselect, l_avm_write_n, l_avm_read_n;
    logic        l_avm_waitrequest = 1'b0;
    logic [31:0] l_avm_writedata, l_avm_readdata;

    easy_avalon_host #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT(255)) u_lat (
        .clk(clk), .reset(reset),
        .cmd_valid(l_cmd_valid), .cmd_ready(l_cmd_ready), .cmd_write(l_cmd_write),
        .cmd_address(l_cmd_address), .cmd_writedata(l_cmd_writedata),
        .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_readdata(l_rsp_readdata),
        .rsp_timeout(l_rsp_timeout),
        .avm_address(l_avm_address), .avm_chipselect(l_avm_chipselect),
        .avm_write_n(l_avm_write_n), .avm_read_n(l_avm_read_n),
        .avm_writedata(l_avm_writedata), .avm_readdata(l_avm_readdata),
        .avm_waitrequest(l_avm_waitrequest)
    );

    // PIO slave: one register at address 0, stalls for stall_target cycles per access
    logic [31:0] reg0 = 32'h0;
    logic [7:0]  stall_cnt = 8'd0;
    int          stall_target = 0;
    always @(posedge clk) begin
        if (reset) reg0 <= 32'h0;
        else if (avm_chipselect && !avm_write_n && !avm_waitrequest && avm_address == 2'd0)
            reg0 <= avm_writedata;
        if (!avm_chipselect) stall_cnt <= 8'd0;
        else stall_cnt <= stall_cnt + 8'd1;
    end
    assign avm_waitrequest = avm_chipselect && (int'(stall_cnt) < stall_target);
    assign avm_readdata    = (avm_chipselect && !avm_read_n && avm_address == 2'd0) ? reg0 : 32'h0;

    // Latency slave: valid data only in the 2nd cycle after the accepted read
    logic [3:0] l_ph = 4'd0;
    always @(posedge clk) begin
        if (l_avm_chipselect && !l_avm_read_n) l_ph <= 4'd1;
        else if (l_ph != 4'd0 && l_ph < 4'd10) l_ph <= l_ph + 4'd1;
    end
    assign l_avm_readdata = (l_ph == 4'd2) ? 32'h12345678 : (32'hBAD0BAD0 ^ {28'h0, l_ph});

    // Bus monitor on the main instance
    int          wr_cyc = 0, rd_cyc = 0;
    logic        bad_inv = 1'b0, bad_stable = 1'b0;
    logic        prev_cs = 1'b0, prev_wn = 1'b1, prev_rn = 1'b1;
    logic [1:0]  prev_a = 2'd0;
    logic [31:0] prev_wd = 32'h0;
    always @(negedge clk) begin
        if (!avm_write_n && !avm_read_n) bad_inv <= 1'b1;
        if ((!avm_write_n || !avm_read_n) && !avm_chipselect) bad_inv <= 1'b1;
        if (avm_chipselect && !avm_write_n) wr_cyc <= wr_cyc + 1;
        if (avm_chipselect && !avm_read_n) rd_cyc <= rd_cyc + 1;
        if (avm_chipselect && prev_cs && (avm_address != prev_a || avm_writedata != prev_wd ||
            avm_write_n != prev_wn || avm_read_n != prev_rn)) bad_stable <= 1'b1;
        prev_cs <= avm_chipselect; prev_a <= avm_address; prev_wd <= avm_writedata;
        prev_wn <= avm_write_n;    prev_rn <= avm_read_n;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic issue(input int idx, input logic w, input logic [1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cmd_write = w; cmd_address = a; cmd_writedata = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        chk("cmd_ready", idx, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_strb;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int n, w0, r0;
        w0 = wr_cyc; r0 = rd_cyc; n = 0;
        stall_target = v.stall;
        issue(idx, v.wr, v.addr, v.wdata);
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk("rsp_valid", idx, 32'(rsp_valid), 32'd1);
        chk("rsp_readdata", idx, rsp_readdata, v.exp_rdata);
        chk("rsp_timeout", idx, 32'(rsp_timeout), 32'(v.exp_to));
        @(negedge clk);
        chk("rsp_drop", idx, 32'(rsp_valid), 32'd0);
        chk("strobe_cycles", idx, 32'(v.wr ? wr_cyc - w0 : rd_cyc - r0), 32'(v.exp_strb));
        chk("other_strobe", idx, 32'(v.wr ? rd_cyc - r0 : wr_cyc - w0), 32'd0);
        stall_target = 0;
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        logic held;
        vecs[0]  = '{1'b1, 2'd0, 32'hDEADBEEF, 0,   32'h0,        1'b0, 1};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,        0,   32'hDEADBEEF, 1'b0, 1};
        vecs[2]  = '{1'b0, 2'd1, 32'h0,        0,   32'h0,        1'b0, 1};
        vecs[3]  = '{1'b1, 2'd2, 32'h00C0FFEE, 3,   32'h0,        1'b0, 4};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,        2,   32'hDEADBEEF, 1'b0, 3};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,        255, 32'h0,        1'b1, 4};
        vecs[6]  = '{1'b0, 2'd0, 32'h0,        0,   32'hDEADBEEF, 1'b0, 1};
        vecs[7]  = '{1'b1, 2'd0, 32'h0000A5A5, 1,   32'h0,        1'b0, 2};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,        0,   32'h0000A5A5, 1'b0, 1};
        vecs[9]  = '{1'b1, 2'd0, 32'h00012345, 3,   32'h0,        1'b0, 4};
        vecs[10] = '{1'b0, 2'd0, 32'h0,        0,   32'h00012345, 1'b0, 1};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_cmd_ready", 0, 32'(cmd_ready), 32'd0);
        chk("rst_cs", 0, 32'(avm_chipselect), 32'd0);
        chk("rst_strobes", 0, 32'({avm_write_n, avm_read_n}), 32'd3);
        chk("rst_addr_wd", 0, avm_writedata | 32'(avm_address), 32'h0);
        chk("rst_rsp", 0, rsp_readdata | 32'({rsp_valid, rsp_timeout}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 0, 32'(cmd_ready), 32'd1);

        // Latency-2 read
        l_cmd_write = 1'b0; l_cmd_address = 2'd0; l_cmd_valid = 1'b1;
        chk("lat_cmd_ready", 0, 32'(l_cmd_ready), 32'd1);
        @(negedge clk);
        l_cmd_valid = 1'b0;
        n = 0;
        while (!l_rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("lat_rsp_valid", 0, 32'(l_rsp_valid), 32'd1);
        chk("lat_cycles", 0, 32'(n), 32'd3);
        chk("lat_readdata", 0, l_rsp_readdata, 32'h12345678);
        chk("lat_timeout", 0, 32'(l_rsp_timeout), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-to-back timing: accept at N, strobe N..N+1, rsp after N+1, ready after N+2
        cmd_write = 1'b1; cmd_address = 2'd3; cmd_writedata = 32'h777; cmd_valid = 1'b1;
        chk("tm_ready0", 0, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("tm_strobe", 0, 32'({avm_chipselect, avm_write_n, avm_read_n}), 32'b101);
        chk("tm_wd", 0, avm_writedata, 32'h777);
        chk("tm_busy", 0, 32'({rsp_valid, cmd_ready}), 32'd0);
        @(negedge clk);
        chk("tm_rsp", 0, 32'({avm_chipselect, rsp_valid, cmd_ready}), 32'b010);
        @(negedge clk);
        chk("tm_ready1", 0, 32'({rsp_valid, cmd_ready}), 32'b01);

        // Response back-pressure with cmd_valid held high
        rsp_ready = 1'b0;
        cmd_write = 1'b0; cmd_address = 2'd0; cmd_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("bp_valid", 0, 32'(rsp_valid), 32'd1);
        n = rd_cyc + wr_cyc;
        held = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!(rsp_valid && rsp_readdata == 32'h00012345 && !rsp_timeout && !cmd_ready
                  && !avm_chipselect)) held = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", 0, 32'(held), 32'd1);
        chk("bp_no_strobe", 0, 32'(rd_cyc + wr_cyc - n), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after", 0, 32'({rsp_valid, cmd_ready}), 32'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_second", 0, rsp_readdata, 32'h00012345);
        @(negedge clk);

        // Reset during a stalled access
        stall_target = 255;
        issue(99, 1'b1, 2'd1, 32'hCAFE0001);
        chk("rs_cs", 0, 32'(avm_chipselect), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_strobes", 0, 32'({avm_chipselect, avm_write_n, avm_read_n}), 32'b011);
        chk("rs_rsp", 0, 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        held = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready || avm_chipselect) held = 1'b0;
        end
        chk("rs_quiet_ready", 0, 32'(held), 32'd1);
        stall_target = 0;
        run_vec(11, '{1'b1, 2'd0, 32'h0000BEEF, 0, 32'h0, 1'b0, 1});
        run_vec(12, '{1'b0, 2'd0, 32'h0,        0, 32'h0000BEEF, 1'b0, 1});

        chk("invariant", 0, 32'(bad_inv), 32'd0);
        chk("stable", 0, 32'(bad_stable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/easy_avalon_host.md
Name: easy_avalon_host

Overview:
Avalon-MM initiator (host) that drives simple memory-mapped slaves such as the easy_* PIO peripherals from a valid/ready command stream.
- Converts each command into one single-beat read or write, honouring waitrequest and fixed read latency.
- Returns one response per command, including write acknowledgements.
- Used by on-chip controllers (sequencers, test logic) that must program PIO registers without a CPU.

Parameters:
ADDR_W, 2, width of cmd_address / avm_address
DATA_W, 32, data width
READ_LATENCY, 0, slave read latency in cycles after the accepted read; legal 0..7
TIMEOUT, 255, max consecutive waitrequest-high cycles before abort; legal 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  host can accept a command
cmd_write  in  1  1=write, 0=read
cmd_address  in  ADDR_W  target word address
cmd_writedata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_readdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_timeout  out  1  access aborted by timeout
avm_address  out  ADDR_W  slave address
avm_chipselect  out  1  slave select
avm_write_n  out  1  active-low write strobe
avm_read_n  out  1  active-low read strobe
avm_writedata  out  DATA_W  slave write data
avm_readdata  in  DATA_W  slave read data
avm_waitrequest  in  1  slave stall

Behaviour:
- One clock (clk); reset is synchronous and active-high, sampled only on the rising edge of clk.
- While reset is high, on each edge:
  - state <= IDLE.
  - avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0.
  - rsp_valid=0, rsp_readdata=0, rsp_timeout=0.
  - cmd_ready=0 and counters cleared.
- All outputs are registered, except cmd_ready, which is defined as (state==IDLE && !reset).
- FSM states and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch cmd_write, cmd_address and cmd_writedata into the avm_* registers. Set chipselect=1 and either write_n=0 (write) or read_n=0 (read). Clear the wait counter. Go to ACCESS.
  - ACCESS: strobes, address and writedata are held stable.
    - avm_waitrequest=1: increment the wait counter. When the counter reaches TIMEOUT, deassert the strobes, set rsp_timeout=1 and rsp_readdata=0, and go to RESP.
    - avm_waitrequest=0: the access completes this cycle and strobes deassert on the next edge.
    - Write: rsp_readdata=0, go to RESP.
    - Read with READ_LATENCY=0: capture avm_readdata this cycle, go to RESP.
    - Read with READ_LATENCY>0: load the latency counter, go to WAIT_DATA.
  - WAIT_DATA: strobes deasserted. Decrement the latency counter each cycle and capture avm_readdata exactly READ_LATENCY cycles after the completing ACCESS cycle, then go to RESP.
  - RESP: rsp_valid=1. rsp_readdata and rsp_timeout are held stable until rsp_valid && rsp_ready. On that handshake: rsp_valid=0, rsp_timeout=0, go to IDLE.
- Timing for a zero-wait write or latency-0 read:
  - Command accepted at edge N; strobes visible N..N+1.
  - rsp_valid high after edge N+1.
  - With rsp_ready=1, next cmd_ready after edge N+2, giving one command per 3 cycles.
- Invariants:
  - avm_write_n and avm_read_n are never both 0.
  - Strobes are asserted only in ACCESS and chipselect=1 only in ACCESS.
  - No new command is accepted until the previous response has been taken.
- Timeout: the counter counts only waitrequest-high cycles of the current access. An aborted access never returns data, and a late avm_readdata is ignored.
- Reset mid-operation: any state returns to IDLE on the reset edge, strobes drop on that edge, and the pending response is discarded (no rsp_valid).
- rsp_ready held high while in IDLE or ACCESS has no effect.

Test Plan:
1. PIO-like slave model (address 0 register, waitrequest=0, READ_LATENCY=0): write 0xDEADBEEF to address 0 -> exactly one cycle with chipselect=1, write_n=0, writedata=0xDEADBEEF; rsp_valid with rsp_readdata=0, rsp_timeout=0. Then read address 0 -> rsp_readdata=0xDEADBEEF. Then read address 1 -> rsp_readdata=0.
2. waitrequest held high 3 cycles on a write to address 2 -> strobe, address 2 and writedata stable for 4 cycles; one response with rsp_timeout=0.
3. TIMEOUT=4, waitrequest stuck high on a read -> strobes deassert after 4 stall cycles; rsp_timeout=1, rsp_readdata=0; the next command is accepted normally.
4. READ_LATENCY=2, slave drives 0x12345678 exactly 2 cycles after the accepted read (garbage otherwise) -> rsp_readdata=0x12345678.
5. rsp_ready low for 5 cycles with cmd_valid continuously high -> rsp_valid and its data stay stable, cmd_ready stays 0 and no avm strobe appears; cmd_ready returns the cycle after the rsp handshake.
6. Assert reset for 1 cycle during ACCESS with waitrequest=1 -> strobes=1/1, chipselect=0 and rsp_valid=0 after that edge; no response is produced; cmd_ready=1 the cycle after reset drops.
